// File: rtl/r5p_mdu.sv
// r5p_mdu: iterative multiply/divide unit for the RISC-V M extension.
// It accepts one operation at a time over a valid/ready request channel,
// computes it one radix-2 step per cycle and returns the rd value over a
// valid/ready response channel.
//
// Ports
//   clk      clock (all state updates on the rising edge)
//   rst      synchronous active-high reset
//   req_vld  request valid
//   req_rdy  request ready (high only in IDLE)
//   fn3      funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   word     *W operation (XLEN=64 only; treated as 0 when XLEN=32)
//   rs1      multiplicand / dividend
//   rs2      multiplier / divisor
//   rsp_vld  response valid (high only in DONE)
//   rsp_rdy  response ready
//   rd       result, held stable while rsp_vld=1
module r5p_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_vld,
  output logic            req_rdy,
  input  logic [2:0]      fn3,
  input  logic            word,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [XLEN-1:0] rd
);

  localparam int W2 = 2 * XLEN;
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;

  // Latched operation and datapath registers (not reset; qualified by state)
  logic [2:0]      fn_r;
  logic            word_r;
  logic            neg_q, neg_r;
  logic [W2-1:0]   mc, prod;
  logic [XLEN-1:0] mp, rem, dvs, rd_r;

  // 32-bit value extended to XLEN, signed or unsigned.
  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
    if (sgn) return XLEN'($signed(v));
    else     return XLEN'(v);
  endfunction

  // Conditional two's-complement negation.
  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Word results are sign-extended from bit 31, whatever the operation.
  function automatic logic [XLEN-1:0] fmt_rd(input logic [XLEN-1:0] v, input logic w);
    return w ? ext32(v[31:0], 1'b1) : v;
  endfunction

  // ---------------------------------------------------------------------
  // Accept-time operand preparation
  // ---------------------------------------------------------------------
  logic            w_in, is_div, s1, s2, neg1, neg2;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, mneg, spec_res;

  always_comb begin
    w_in   = (XLEN == 64) && word;
    is_div = fn3[2];
    // MUL low bits do not depend on signedness, so it runs unsigned.
    s1     = (fn3 == 3'd1) || (fn3 == 3'd2) || (fn3 == 3'd4) || (fn3 == 3'd6);
    s2     = (fn3 == 3'd1) || (fn3 == 3'd4) || (fn3 == 3'd6);
    a_ext  = w_in ? ext32(rs1[31:0], s1) : rs1;
    b_ext  = w_in ? ext32(rs2[31:0], s2) : rs2;
    neg1   = s1 && a_ext[XLEN-1];
    neg2   = s2 && b_ext[XLEN-1];
    a_mag  = cneg(a_ext, neg1);
    b_mag  = cneg(b_ext, neg2);
    // Most-negative value of the operation width, as seen after extension
    mneg   = w_in ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};

    div_zero = is_div && (b_ext == '0);
    div_ovf  = is_div && !fn3[0] && (a_ext == mneg) && (b_ext == '1);
    special  = div_zero || div_ovf;

    spec_res = '0;
    if (div_zero)     spec_res = fn3[1] ? a_ext : '1;
    else if (div_ovf) spec_res = fn3[1] ? '0 : a_ext;
  end

  // ---------------------------------------------------------------------
  // One radix-2 step, plus the sign fixup applied on the last step
  // ---------------------------------------------------------------------
  logic [W2-1:0]   prod_s, mc_s, p_fix;
  logic [XLEN-1:0] mp_s, rem_s, mul_res, div_res, res;
  logic [XLEN:0]   trial, diff;
  logic            ge;

  always_comb begin
    // Shift-add multiply: multiplicand walks left, multiplier walks right
    prod_s = mp[0] ? (prod + mc) : prod;
    mc_s   = mc << 1;

    // Restoring divide: dividend bits shift out of mp, quotient bits shift in
    trial  = {rem, mp[XLEN-1]};
    diff   = trial - {1'b0, dvs};
    ge     = !diff[XLEN];
    rem_s  = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];

    mp_s   = fn_r[2] ? {mp[XLEN-2:0], ge} : (mp >> 1);

    p_fix  = neg_q ? (~prod_s + 1'b1) : prod_s;
    if (fn_r[1:0] == 2'd0) mul_res = p_fix[XLEN-1:0];
    else if (word_r)       mul_res = XLEN'(p_fix[63:32]);
    else                   mul_res = p_fix[W2-1:XLEN];

    div_res = fn_r[1] ? cneg(rem_s, neg_r) : cneg(mp_s, neg_q);
    res     = fn_r[2] ? div_res : mul_res;
  end

  // ---------------------------------------------------------------------
  // FSM next state and handshake outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    req_rdy   = 1'b0;
    rsp_vld   = 1'b0;
    case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_vld) state_nxt = special ? DONE : BUSY;
      end
      BUSY: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        rsp_vld = 1'b1;
        if (rsp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_vld)
        cnt <= w_in ? CW'(31) : CW'(XLEN - 1);
      else if (state == BUSY && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (req_vld) begin
          fn_r   <= fn3;
          word_r <= w_in;
          neg_q  <= neg1 ^ neg2;
          neg_r  <= neg1;
          mc     <= W2'(a_mag);
          prod   <= '0;
          rem    <= '0;
          dvs    <= b_mag;
          // Word dividends are left-aligned so their MSB is shifted out first
          if (is_div) mp <= w_in ? (a_mag << (XLEN - 32)) : a_mag;
          else        mp <= b_mag;
          if (special) rd_r <= fmt_rd(spec_res, w_in);
        end
      end
      BUSY: begin
        prod <= prod_s;
        mc   <= mc_s;
        mp   <= mp_s;
        rem  <= rem_s;
        if (cnt == '0) rd_r <= fmt_rd(res, word_r);
      end
      default: ;
    endcase
  end

  assign rd = rd_r;

endmodule
